// File: rtl/hazard_ctrl.sv
// Registered hazard controller for the five-stage MIPS pipeline: load-use stalls, redirect flushes,
// data-memory wait freeze and fetch-miss bubbles. HAZARD_PERF_EN adds stall/flush event counters.
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_STALLS  = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              exmem_dren,
    input  logic              exmem_dwen,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_uses_rt,
    input  logic              idex_dren,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [1:0]        idex_pcsrc,
    input  logic              idex_brtaken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        hz_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_STALLS - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         LU_MULTI  = (LOAD_STALLS > 1);
    localparam bit         FL_MULTI  = (FLUSH_CYCLES > 1);

    state_t     state, ret_state, eff_state, state_nx, ret_nx;
    logic [2:0] cnt, cnt_nx;
    logic       memwait, redirect, loaduse, redirect_acc;

    // ihit/dhit are single-cycle completion strobes: a cycle without them must not advance that stage.
    assign memwait  = (exmem_dren | exmem_dwen) & ~dhit;
    assign redirect = (idex_pcsrc == 2'b01) | (idex_pcsrc == 2'b11)
                    | ((idex_pcsrc == 2'b10) & idex_brtaken);
    assign loaduse  = idex_dren & (idex_rt != '0)
                    & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

    // The dhit cycle already behaves as the interrupted state, so a wait costs only the dhit-low cycles.
    assign eff_state = (state == MEM_WAIT) ? ret_state : state;
    assign hz_state  = state;

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        state_nx     = eff_state;
        ret_nx       = ret_state;
        cnt_nx       = cnt;
        redirect_acc = 1'b0;
        if (memwait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_nx = MEM_WAIT;
            ret_nx   = eff_state;
        end else if (redirect) begin
            redirect_acc = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            if (FL_MULTI) begin
                state_nx = FLUSH;
                cnt_nx   = FL_RELOAD;
            end else begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        end else begin
            case (eff_state)
                FLUSH: begin
                    ifid_flush = 1'b1;
                    pc_en      = ihit;
                    cnt_nx     = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end
                end
                LU_STALL: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    cnt_nx     = cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    if (loaduse) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        if (LU_MULTI) begin
                            state_nx = LU_STALL;
                            cnt_nx   = LU_RELOAD;
                        end
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
            endcase
        end
        if (!nRST) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            redirect_acc = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            ret_state <= RUN;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            cnt       <= cnt_nx;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en)       stall_cnt <= stall_cnt + 32'd1;
            if (redirect_acc) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_STALLS=1/FLUSH_CYCLES=1 and LOAD_STALLS=3/FLUSH_CYCLES=2)
// share stimulus; per-cycle expected outputs of both go through a scoreboard queue.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ihit, dhit, exmem_dren, exmem_dwen, ifid_uses_rt, idex_dren, idex_brtaken;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic [1:0] idex_pcsrc;
    wire  [6:0] a_o, b_o;
    wire  [1:0] a_hz, b_hz;
`ifdef HAZARD_PERF_EN
    wire [31:0] a_stall, a_flush, b_stall, b_flush;
`endif

    hazard_ctrl #(.REG_AW(5), .LOAD_STALLS(1), .FLUSH_CYCLES(1)) dut_a (
        .CLK(clk), .nRST(rst_n), .ihit(ihit), .dhit(dhit), .exmem_dren(exmem_dren),
        .exmem_dwen(exmem_dwen), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_dren(idex_dren), .idex_rt(idex_rt), .idex_pcsrc(idex_pcsrc), .idex_brtaken(idex_brtaken),
        .pc_en(a_o[6]), .ifid_en(a_o[5]), .idex_en(a_o[4]), .exmem_en(a_o[3]), .memwb_en(a_o[2]),
        .ifid_flush(a_o[1]), .idex_flush(a_o[0]), .hz_state(a_hz)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(a_stall), .flush_cnt(a_flush)
`endif
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_STALLS(3), .FLUSH_CYCLES(2)) dut_b (
        .CLK(clk), .nRST(rst_n), .ihit(ihit), .dhit(dhit), .exmem_dren(exmem_dren),
        .exmem_dwen(exmem_dwen), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .idex_dren(idex_dren), .idex_rt(idex_rt), .idex_pcsrc(idex_pcsrc), .idex_brtaken(idex_brtaken),
        .pc_en(b_o[6]), .ifid_en(b_o[5]), .idex_en(b_o[4]), .exmem_en(b_o[3]), .memwb_en(b_o[2]),
        .ifid_flush(b_o[1]), .idex_flush(b_o[0]), .hz_state(b_hz)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(b_stall), .flush_cnt(b_flush)
`endif
    );

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
    localparam logic [6:0] RUNO = 7'b1111100;
    localparam logic [6:0] LUO  = 7'b0011101;
    localparam logic [6:0] REDO = 7'b1111111;
    localparam logic [6:0] FLO  = 7'b1111110;
    localparam logic [6:0] MWO  = 7'b0000000;
    localparam logic [6:0] NIH  = 7'b0111110;
    localparam logic [6:0] RSTO = 7'b0000011;

    typedef struct packed {
        logic        rn, ih, mrd, dh, ldr;
        logic [4:0]  lrt, rs, rt;
        logic        urt;
        logic [1:0]  pcs;
        logic        bt;
        logic [17:0] e;
    } step_t;

    logic [17:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [17:0] ex(input logic [6:0] oa, input logic [1:0] sa,
                                       input logic [6:0] ob, input logic [1:0] sb);
        return {ob, sb, oa, sa};
    endfunction

    function automatic step_t mk(input logic rn, input logic ih, input logic mrd, input logic dh,
                                 input logic ldr, input logic [4:0] lrt, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic urt, input logic [1:0] pcs,
                                 input logic bt, input logic [17:0] e);
        return '{rn: rn, ih: ih, mrd: mrd, dh: dh, ldr: ldr, lrt: lrt, rs: rs, rt: rt,
                 urt: urt, pcs: pcs, bt: bt, e: e};
    endfunction

    function automatic step_t idle(input logic [17:0] e);
        return mk(1, 1, 0, 1, 0, 5'd3, 5'd1, 5'd2, 0, 2'd0, 0, e);
    endfunction

    function automatic step_t lu(input logic [17:0] e);
        return mk(1, 1, 0, 1, 1, 5'd8, 5'd8, 5'd2, 0, 2'd0, 0, e);
    endfunction

    function automatic step_t jmp(input logic [1:0] pcs, input logic bt, input logic [17:0] e);
        return mk(1, 1, 0, 1, 0, 5'd3, 5'd1, 5'd2, 0, pcs, bt, e);
    endfunction

    function automatic logic [17:0] outs();
        return {b_o, b_hz, a_o, a_hz};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic apply(input step_t s);
        @(posedge clk);
        #1;
        rst_n        = s.rn;
        ihit         = s.ih;
        exmem_dren   = s.mrd;
        exmem_dwen   = 1'b0;
        dhit         = s.dh;
        idex_dren    = s.ldr;
        idex_rt      = s.lrt;
        ifid_rs      = s.rs;
        ifid_rt      = s.rt;
        ifid_uses_rt = s.urt;
        idex_pcsrc   = s.pcs;
        idex_brtaken = s.bt;
        exp_q.push_back(s.e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [17:0] got, want;
        s.push_back(mk(0, 1, 0, 1, 0, 5'd3, 5'd1, 5'd2, 0, 2'd0, 0, ex(RSTO, 0, RSTO, 0)));
        s.push_back(mk(0, 1, 0, 1, 1, 5'd8, 5'd8, 5'd2, 0, 2'd3, 0, ex(RSTO, 0, RSTO, 0)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = outs(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL reset[%0d]: got %b, want %b", i, got, want);
            end
        end
    endtask

    task automatic test_run();
        step_t s[$];
        logic [17:0] got, want;
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        s.push_back(mk(1, 0, 0, 1, 0, 5'd3, 5'd1, 5'd2, 0, 2'd0, 0, ex(NIH, 0, NIH, 0)));
        s.push_back(jmp(2'd2, 0, ex(RUNO, 0, RUNO, 0)));
        s.push_back(mk(1, 1, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 2'd0, 0, ex(RUNO, 0, RUNO, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = outs(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL run[%0d]: got %b, want %b", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        logic [17:0] got, want;
        s.push_back(lu(ex(LUO, 0, LUO, 0)));
        s.push_back(idle(ex(RUNO, 0, LUO, 1)));
        s.push_back(idle(ex(RUNO, 0, LUO, 1)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        s.push_back(mk(1, 1, 0, 1, 1, 5'd9, 5'd1, 5'd9, 1, 2'd0, 0, ex(LUO, 0, LUO, 0)));
        s.push_back(idle(ex(RUNO, 0, LUO, 1)));
        s.push_back(idle(ex(RUNO, 0, LUO, 1)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        s.push_back(mk(1, 1, 0, 1, 1, 5'd9, 5'd1, 5'd9, 0, 2'd0, 0, ex(RUNO, 0, RUNO, 0)));
        s.push_back(mk(1, 0, 0, 1, 1, 5'd8, 5'd8, 5'd2, 0, 2'd0, 0, ex(LUO, 0, LUO, 0)));
        s.push_back(idle(ex(RUNO, 0, LUO, 1)));
        s.push_back(idle(ex(RUNO, 0, LUO, 1)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = outs(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL load_use[%0d]: got %b, want %b", i, got, want);
            end
        end
    endtask

    task automatic test_redirect();
        step_t s[$];
        logic [17:0] got, want;
        s.push_back(jmp(2'd2, 1, ex(REDO, 0, REDO, 0)));
        s.push_back(idle(ex(RUNO, 0, FLO, 2)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        s.push_back(jmp(2'd1, 0, ex(REDO, 0, REDO, 0)));
        s.push_back(mk(1, 0, 0, 1, 0, 5'd3, 5'd1, 5'd2, 0, 2'd0, 0, ex(NIH, 0, NIH, 2)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        s.push_back(jmp(2'd3, 0, ex(REDO, 0, REDO, 0)));
        s.push_back(jmp(2'd3, 0, ex(REDO, 0, REDO, 2)));
        s.push_back(idle(ex(RUNO, 0, FLO, 2)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = outs(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL redirect[%0d]: got %b, want %b", i, got, want);
            end
        end
    endtask

    task automatic test_mem_wait();
        step_t s[$];
        logic [17:0] got, want;
        s.push_back(lu(ex(LUO, 0, LUO, 0)));
        s.push_back(idle(ex(RUNO, 0, LUO, 1)));
        s.push_back(mk(1, 1, 1, 0, 0, 5'd3, 5'd1, 5'd2, 0, 2'd0, 0, ex(MWO, 0, MWO, 1)));
        for (int k = 0; k < 3; k++)
            s.push_back(mk(1, 1, 1, 0, 0, 5'd3, 5'd1, 5'd2, 0, 2'd0, 0, ex(MWO, 3, MWO, 3)));
        s.push_back(mk(1, 1, 1, 1, 0, 5'd3, 5'd1, 5'd2, 0, 2'd0, 0, ex(RUNO, 3, LUO, 3)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        s.push_back(mk(1, 1, 1, 0, 1, 5'd8, 5'd8, 5'd2, 0, 2'd3, 0, ex(MWO, 0, MWO, 0)));
        s.push_back(mk(1, 1, 1, 1, 1, 5'd8, 5'd8, 5'd2, 0, 2'd3, 0, ex(REDO, 3, REDO, 3)));
        s.push_back(idle(ex(RUNO, 0, FLO, 2)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = outs(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL mem_wait[%0d]: got %b, want %b", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        logic [17:0] got, want;
        s.push_back(mk(1, 1, 0, 1, 1, 5'd8, 5'd8, 5'd2, 0, 2'd3, 0, ex(REDO, 0, REDO, 0)));
        s.push_back(idle(ex(RUNO, 0, FLO, 2)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        s.push_back(jmp(2'd2, 1, ex(REDO, 0, REDO, 0)));
        s.push_back(mk(0, 1, 0, 1, 0, 5'd3, 5'd1, 5'd2, 0, 2'd0, 0, ex(RSTO, 0, RSTO, 0)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = outs(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %b, want %b", i, got, want);
            end
        end
    endtask

    task automatic test_perf();
        step_t s[$];
        logic [17:0] got, want;
        s.push_back(mk(0, 1, 0, 1, 0, 5'd3, 5'd1, 5'd2, 0, 2'd0, 0, ex(RSTO, 0, RSTO, 0)));
        for (int k = 0; k < 3; k++) begin
            s.push_back(lu(ex(LUO, 0, LUO, 0)));
            s.push_back(idle(ex(RUNO, 0, LUO, 1)));
            s.push_back(idle(ex(RUNO, 0, LUO, 1)));
            s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        end
        s.push_back(jmp(2'd3, 0, ex(REDO, 0, REDO, 0)));
        s.push_back(idle(ex(RUNO, 0, FLO, 2)));
        s.push_back(idle(ex(RUNO, 0, RUNO, 0)));
        foreach (s[i]) begin
            apply(s[i]);
            got = outs(); want = exp_q.pop_front(); tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL perf_seq[%0d]: got %b, want %b", i, got, want);
            end
        end
`ifdef HAZARD_PERF_EN
        tests++;
        if ({a_stall, a_flush} !== {32'd3, 32'd1}) begin
            fails++;
            $display("FAIL perf_a: stall %0d flush %0d, want 3 1", a_stall, a_flush);
        end
        tests++;
        if ({b_stall, b_flush} !== {32'd9, 32'd1}) begin
            fails++;
            $display("FAIL perf_b: stall %0d flush %0d, want 9 1", b_stall, b_flush);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0; ihit = 1'b1; dhit = 1'b1; exmem_dren = 1'b0; exmem_dwen = 1'b0;
        ifid_rs = 5'd1; ifid_rt = 5'd2; ifid_uses_rt = 1'b0; idex_dren = 1'b0;
        idex_rt = 5'd3; idex_pcsrc = 2'd0; idex_brtaken = 1'b0;
        test_reset();
        test_run();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_back_to_back();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
